uart_rx_cfg: RTL and testbench

Parametrised next-generation RS-232 receiver. Supports configurable word length, parity mode (none, even or odd) and stop-bit count. Samples each bit at 16x (OSR) oversampling with a 3-sample majority vote. Reports parity, framing, overrun and break conditions alongside a held data register with a read-acknowledge handshake. Sits between the board Rx pin and the consumer logic (display, FIFO, command decoder).

---
 rtl/uart_rx_pkg.sv | 22 ++
 rtl/uart_os_tick.sv | 30 +++
 rtl/uart_rx_cfg.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the configurable UART receiver.
package uart_rx_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4,
    StBreak  = 3'd5
  } rx_state_e;

  // 2-of-3 vote used to reject single-sample glitches.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: one-CLK pulse every DIV cycles, clearable for phase alignment.
module uart_os_tick #(
  parameter int unsigned DIV   = 651,
  parameter int unsigned DIV_W = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic CLR,
  output logic TICK
);

  localparam logic [DIV_W-1:0] Last = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign TICK = (cnt_q == Last);

  // Wrap at DIV-1; CLR restarts the period so ticks line up with the start edge.
  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (CLR || TICK) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable RS-232 receiver: synchroniser, oversampled bit FSM, shift register and
// held output register with read-acknowledge handshake.
module uart_rx_cfg
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned OSR       = 16,
  parameter int unsigned DIV       = 651,
  parameter int unsigned DIV_W     = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Rx,
  input  logic                 ACK,
  output logic [DATA_BITS-1:0] D,
  output logic                 DV,
  output logic                 PERR,
  output logic                 FERR,
  output logic                 OVR,
  output logic                 BRK,
  output logic                 BUSY
);

  localparam int unsigned SW = $clog2(OSR);
  localparam logic [SW-1:0] SMid0    = SW'(OSR / 2 - 1);
  localparam logic [SW-1:0] SMid1    = SW'(OSR / 2);
  localparam logic [SW-1:0] SDec     = SW'(OSR / 2 + 1);
  localparam logic [SW-1:0] SLast    = SW'(OSR - 1);
  localparam logic [3:0]    LastData = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LastStop = 4'(STOP_BITS - 1);

  logic rx_meta_q, rx_s_q, rx_prev_q;
  rx_state_e state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [3:0] bit_q, bit_d;
  logic [1:0] smp_q, smp_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic zero_q, zero_d, perr_f_q, perr_f_d, ferr_f_q, ferr_f_d, brk_f_q, brk_f_d;
  logic done_q, done_d;
  logic [DATA_BITS-1:0] d_q, d_d;
  logic dv_q, dv_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d, brk_q, brk_d;

  logic tick, start_edge, maj, dec, bit_end, brk_now;

  assign start_edge = (state_q == StIdle) && rx_prev_q && !rx_s_q;
  assign maj        = majority3(smp_q[0], smp_q[1], rx_s_q);
  assign dec        = tick && (s_q == SDec);
  assign bit_end    = tick && (s_q == SLast);
  // With two stop bits the break verdict was already taken at the first one.
  assign brk_now    = (bit_q == 4'd0) ? (~maj & zero_q) : brk_f_q;

  uart_os_tick #(
    .DIV   (DIV),
    .DIV_W (DIV_W)
  ) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .CLR  (start_edge),
    .TICK (tick)
  );

  // Two-flop synchroniser plus previous-value flop for the falling-edge detect.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= Rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // Frame FSM next-state, sub-bit counter, sampling and shift logic.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    bit_d    = bit_q;
    smp_d    = smp_q;
    shreg_d  = shreg_q;
    zero_d   = zero_q;
    perr_f_d = perr_f_q;
    ferr_f_d = ferr_f_q;
    brk_f_d  = brk_f_q;
    done_d   = 1'b0;

    if ((state_q inside {StStart, StData, StParity, StStop}) && tick) begin
      s_d = (s_q == SLast) ? '0 : s_q + SW'(1);
      if (s_q == SMid0) smp_d[0] = rx_s_q;
      if (s_q == SMid1) smp_d[1] = rx_s_q;
    end

    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d  = StStart;
          s_d      = '0;
          bit_d    = '0;
          zero_d   = 1'b1;
          perr_f_d = 1'b0;
          ferr_f_d = 1'b0;
          brk_f_d  = 1'b0;
        end
      end
      StStart: begin
        if (dec && maj)   state_d = StIdle;
        else if (bit_end) state_d = StData;
      end
      StData: begin
        if (dec) begin
          shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
          if (maj) zero_d = 1'b0;
        end
        if (bit_end) begin
          if (bit_q == LastData) begin
            bit_d   = '0;
            state_d = (PARITY != PAR_NONE) ? StParity : StStop;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      StParity: begin
        if (dec) begin
          perr_f_d = (^shreg_q) ^ maj ^ (PARITY == PAR_ODD);
          if (maj) zero_d = 1'b0;
        end
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (bit_end) bit_d = bit_q + 4'd1;
        if (dec) begin
          if (bit_q == 4'd0) begin
            ferr_f_d = ~maj;
            brk_f_d  = ~maj & zero_q;
          end
          if (bit_q == LastStop) begin
            done_d  = 1'b1;
            s_d     = '0;
            state_d = brk_now ? StBreak : StIdle;
          end
        end
      end
      StBreak: begin
        // Need OSR consecutive high ticks before re-arming.
        if (tick) begin
          if (!rx_s_q) begin
            s_d = '0;
          end else if (s_q == SLast) begin
            s_d     = '0;
            state_d = StIdle;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output register and handshake; a load always wins over ACK.
  always_comb begin
    d_d    = d_q;
    dv_d   = dv_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    ovr_d  = ovr_q;
    brk_d  = brk_q;
    if (done_q) begin
      d_d    = shreg_q;
      perr_d = perr_f_q;
      ferr_d = ferr_f_q;
      brk_d  = brk_f_q;
      dv_d   = 1'b1;
      ovr_d  = ACK ? 1'b0 : (dv_q | ovr_q);
    end else if (ACK && dv_q) begin
      dv_d  = 1'b0;
      ovr_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StIdle;
      s_q      <= '0;
      bit_q    <= '0;
      smp_q    <= '0;
      shreg_q  <= '0;
      zero_q   <= 1'b0;
      perr_f_q <= 1'b0;
      ferr_f_q <= 1'b0;
      brk_f_q  <= 1'b0;
      done_q   <= 1'b0;
      d_q      <= '0;
      dv_q     <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
      brk_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      bit_q    <= bit_d;
      smp_q    <= smp_d;
      shreg_q  <= shreg_d;
      zero_q   <= zero_d;
      perr_f_q <= perr_f_d;
      ferr_f_q <= ferr_f_d;
      brk_f_q  <= brk_f_d;
      done_q   <= done_d;
      d_q      <= d_d;
      dv_q     <= dv_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
      brk_q    <= brk_d;
    end
  end

  assign D    = d_q;
  assign DV   = dv_q;
  assign PERR = perr_q;
  assign FERR = ferr_q;
  assign OVR  = ovr_q;
  assign BRK  = brk_q;
  assign BUSY = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations (8N1, 7E1, 8O2) on separate lines.
module tb_uart_rx_cfg;

  localparam int BIT = 64;  // DIV(4) * OSR(16) clocks per bit

  logic CLK = 1'b0;
  logic RST;
  logic [2:0] rx, ack;
  wire  [7:0] d0, d2;
  wire  [6:0] d1;
  wire  [2:0] dv, perr, ferr, ovr, brk, busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         u;
    logic [8:0] d;
    logic       perr, ferr, ovr, brk;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int         u;
    logic [8:0] data;
    int         par;     // -1: no parity bit sent
    logic       stop0;
    int         glitch;  // data bit index to glitch, -1 none
    logic       ack;
    logic [8:0] ed;
    logic       ep, ef, eo, eb;
  } vec_t;
  vec_t vt[9];

  always #5 CLK = ~CLK;

  uart_rx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OSR(16), .DIV(4), .DIV_W(4)) u_8n1 (
    .CLK(CLK), .RST(RST), .Rx(rx[0]), .ACK(ack[0]), .D(d0), .DV(dv[0]), .PERR(perr[0]),
    .FERR(ferr[0]), .OVR(ovr[0]), .BRK(brk[0]), .BUSY(busy[0]));
  uart_rx_cfg #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .OSR(16), .DIV(4), .DIV_W(4)) u_7e1 (
    .CLK(CLK), .RST(RST), .Rx(rx[1]), .ACK(ack[1]), .D(d1), .DV(dv[1]), .PERR(perr[1]),
    .FERR(ferr[1]), .OVR(ovr[1]), .BRK(brk[1]), .BUSY(busy[1]));
  uart_rx_cfg #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .OSR(16), .DIV(4), .DIV_W(4)) u_8o2 (
    .CLK(CLK), .RST(RST), .Rx(rx[2]), .ACK(ack[2]), .D(d2), .DV(dv[2]), .PERR(perr[2]),
    .FERR(ferr[2]), .OVR(ovr[2]), .BRK(brk[2]), .BUSY(busy[2]));

  function automatic logic [8:0] get_d(input int u);
    if (u == 0) return {1'b0, d0};
    if (u == 1) return {2'b00, d1};
    return {1'b0, d2};
  endfunction

  function automatic int nbits(input int u);
    return (u == 1) ? 7 : 8;
  endfunction

  function automatic int nstop(input int u);
    return (u == 2) ? 2 : 1;
  endfunction

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic drive_bit(input int u, input logic b, input bit glitch);
    rx[u] = b;
    if (glitch) begin
      idle(32);
      rx[u] = ~b;
      idle(4);  // one oversample tick
      rx[u] = b;
      idle(BIT - 36);
    end else begin
      idle(BIT);
    end
  endtask

  task automatic send_frame(input int u, input logic [8:0] data, input int par,
                            input logic stop0, input int glitch);
    drive_bit(u, 1'b0, 1'b0);
    for (int i = 0; i < nbits(u); i++) drive_bit(u, data[i], i == glitch);
    if (par >= 0) drive_bit(u, par[0], 1'b0);
    drive_bit(u, stop0, 1'b0);
    for (int i = 1; i < nstop(u); i++) drive_bit(u, 1'b1, 1'b0);
    rx[u] = 1'b1;
    idle(32);
  endtask

  task automatic ack_pulse(input int u);
    ack[u] = 1'b1;
    idle(1);
    ack[u] = 1'b0;
  endtask

  // Pop the oldest expectation and compare once the DUT shows a valid word.
  task automatic sb_check(input string tag);
    exp_t e;
    int   n;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 9'd1, 9'd0);
      return;
    end
    e = sb.pop_front();
    n = 0;
    while (!dv[e.u] && n < 4 * BIT) begin
      idle(1);
      n++;
    end
    chk({tag, ".DV"},   {8'd0, dv[e.u]},   9'd1);
    chk({tag, ".D"},    get_d(e.u),        e.d);
    chk({tag, ".PERR"}, {8'd0, perr[e.u]}, {8'd0, e.perr});
    chk({tag, ".FERR"}, {8'd0, ferr[e.u]}, {8'd0, e.ferr});
    chk({tag, ".OVR"},  {8'd0, ovr[e.u]},  {8'd0, e.ovr});
    chk({tag, ".BRK"},  {8'd0, brk[e.u]},  {8'd0, e.brk});
  endtask

  task automatic chk_idle_outputs(input string tag, input int u);
    chk({tag, ".D"},    get_d(u),         9'd0);
    chk({tag, ".DV"},   {8'd0, dv[u]},    9'd0);
    chk({tag, ".PERR"}, {8'd0, perr[u]},  9'd0);
    chk({tag, ".FERR"}, {8'd0, ferr[u]},  9'd0);
    chk({tag, ".OVR"},  {8'd0, ovr[u]},   9'd0);
    chk({tag, ".BRK"},  {8'd0, brk[u]},   9'd0);
    chk({tag, ".BUSY"}, {8'd0, busy[u]},  9'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    bit ack_ok;
    vt[0] = '{0, 9'h0A5, -1, 1'b1, -1, 1'b1, 9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1, 9'h035,  1, 1'b1, -1, 1'b1, 9'h035, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1, 9'h035,  0, 1'b1, -1, 1'b1, 9'h035, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[3] = '{2, 9'h000,  1, 1'b1, -1, 1'b1, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4] = '{2, 9'h096,  0, 1'b1, -1, 1'b1, 9'h096, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[5] = '{0, 9'h03C, -1, 1'b1,  2, 1'b1, 9'h03C, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[6] = '{0, 9'h055, -1, 1'b0, -1, 1'b1, 9'h055, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[7] = '{0, 9'h011, -1, 1'b1, -1, 1'b0, 9'h011, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[8] = '{0, 9'h022, -1, 1'b1, -1, 1'b0, 9'h022, 1'b0, 1'b0, 1'b1, 1'b0};

    RST = 1'b1;
    rx  = 3'b111;
    ack = 3'b000;
    idle(5);
    chk_idle_outputs("reset_held", 0);
    RST = 1'b0;
    idle(5);
    chk_idle_outputs("reset_released", 1);

    for (int k = 0; k < 9; k++) begin
      sb.push_back('{vt[k].u, vt[k].ed, vt[k].ep, vt[k].ef, vt[k].eo, vt[k].eb});
      send_frame(vt[k].u, vt[k].data, vt[k].par, vt[k].stop0, vt[k].glitch);
      sb_check($sformatf("vec%0d", k));
      if (vt[k].ack) begin
        ack_pulse(vt[k].u);
        chk($sformatf("vec%0d.ack_DV", k),  {8'd0, dv[vt[k].u]},  9'd0);
        chk($sformatf("vec%0d.ack_OVR", k), {8'd0, ovr[vt[k].u]}, 9'd0);
      end
    end

    // ACK lands on the load cycle of 0x33 while 0x22 is still unread with OVR set.
    sb.push_back('{0, 9'h033, 1'b0, 1'b0, 1'b0, 1'b0});
    ack_ok = 1'b0;
    fork
      send_frame(0, 9'h033, -1, 1'b1, -1);
      begin
        int n;
        n = 0;
        while (!busy[0] && n < BIT) begin idle(1); n++; end
        n = 0;
        while (busy[0] && n < 12 * BIT) begin idle(1); n++; end
        if (!busy[0]) begin
          ack_ok = 1'b1;
          ack_pulse(0);
        end
      end
    join
    chk("ack_at_load.busy_fell", {8'd0, ack_ok}, 9'd1);
    sb_check("ack_at_load");
    ack_pulse(0);

    // False start: line low for 5 ticks only.
    rx[0] = 1'b0;
    idle(10);
    chk("false_start.busy_rise", {8'd0, busy[0]}, 9'd1);
    idle(10);
    rx[0] = 1'b1;
    idle(BIT + 16);
    chk("false_start.busy_drop", {8'd0, busy[0]}, 9'd0);
    chk("false_start.DV",        {8'd0, dv[0]},   9'd0);

    // Break: 12 bit times low, then recovery requires a full high bit.
    sb.push_back('{0, 9'h000, 1'b0, 1'b1, 1'b0, 1'b1});
    rx[0] = 1'b0;
    idle(12 * BIT);
    sb_check("break");
    chk("break.busy_low_line", {8'd0, busy[0]}, 9'd1);
    rx[0] = 1'b1;
    idle(BIT / 2);
    chk("break.busy_half_bit", {8'd0, busy[0]}, 9'd1);
    idle(BIT / 2 + 16);
    chk("break.busy_released", {8'd0, busy[0]}, 9'd0);
    ack_pulse(0);
    sb.push_back('{0, 9'h07E, 1'b0, 1'b0, 1'b0, 1'b0});
    send_frame(0, 9'h07E, -1, 1'b1, -1);
    sb_check("after_break");

    // Reset in the middle of bit 4 of 0xF0 while 0x7E is still held.
    drive_bit(0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'b0, 1'b0);
    rx[0] = 1'b1;
    idle(32);
    chk("mid_reset.busy_before", {8'd0, busy[0]}, 9'd1);
    RST = 1'b1;
    idle(2);
    RST = 1'b0;
    idle(6 * BIT);
    chk_idle_outputs("mid_reset", 0);
    sb.push_back('{0, 9'h00F, 1'b0, 1'b0, 1'b0, 1'b0});
    send_frame(0, 9'h00F, -1, 1'b1, -1);
    sb_check("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
